// File: rtl/lsu_pkg.sv
// Shared types and ISA decode helpers for the load/store unit.
// The ALU_OPERATIONS_* values mirror the load/store codes of isa.svh.
package lsu_pkg;

  localparam logic [7:0] ALU_OPERATIONS_LB  = 8'h20;
  localparam logic [7:0] ALU_OPERATIONS_LH  = 8'h21;
  localparam logic [7:0] ALU_OPERATIONS_LW  = 8'h22;
  localparam logic [7:0] ALU_OPERATIONS_LBU = 8'h23;
  localparam logic [7:0] ALU_OPERATIONS_LHU = 8'h24;
  localparam logic [7:0] ALU_OPERATIONS_SB  = 8'h25;
  localparam logic [7:0] ALU_OPERATIONS_SH  = 8'h26;
  localparam logic [7:0] ALU_OPERATIONS_SW  = 8'h27;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RSP,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    BYTE,
    HALF,
    WORD
  } size_t;

  typedef logic signed_t;

  function automatic logic op_is_load(input logic [7:0] op);
    case (op)
      ALU_OPERATIONS_LB, ALU_OPERATIONS_LH, ALU_OPERATIONS_LW,
      ALU_OPERATIONS_LBU, ALU_OPERATIONS_LHU: op_is_load = 1'b1;
      default:                                op_is_load = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [7:0] op);
    case (op)
      ALU_OPERATIONS_SB, ALU_OPERATIONS_SH, ALU_OPERATIONS_SW: op_is_store = 1'b1;
      default:                                                 op_is_store = 1'b0;
    endcase
  endfunction

  function automatic size_t op_size(input logic [7:0] op);
    case (op)
      ALU_OPERATIONS_LB, ALU_OPERATIONS_LBU, ALU_OPERATIONS_SB: op_size = BYTE;
      ALU_OPERATIONS_LH, ALU_OPERATIONS_LHU, ALU_OPERATIONS_SH: op_size = HALF;
      default:                                                 op_size = WORD;
    endcase
  endfunction

  function automatic signed_t op_signed(input logic [7:0] op);
    op_signed = (op == ALU_OPERATIONS_LB) || (op == ALU_OPERATIONS_LH);
  endfunction

  function automatic logic is_misaligned(input size_t size, input logic [1:0] off);
    case (size)
      HALF:    is_misaligned = off[0];
      WORD:    is_misaligned = (off != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] align_offset(input size_t size, input logic [1:0] off);
    case (size)
      HALF:    align_offset = {off[1], 1'b0};
      WORD:    align_offset = 2'b00;
      default: align_offset = off;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane logic: store byte enables / replicated data and
// load lane selection with sign or zero extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  size_t       size,
  input  signed_t     sgn,
  input  logic        store,
  input  logic [1:0]  off,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    be    = 4'b1111;
    wdata = '0;
    if (store) begin
      case (size)
        BYTE: begin
          be    = 4'b0001 << off;
          wdata = {4{store_data[7:0]}};
        end
        HALF: begin
          be    = 4'b0011 << {off[1], 1'b0};
          wdata = {2{store_data[15:0]}};
        end
        default: begin
          be    = 4'b1111;
          wdata = store_data;
        end
      endcase
    end
  end

  always_comb begin
    lane_b    = rdata[{off, 3'b000} +: 8];
    lane_h    = off[1] ? rdata[31:16] : rdata[15:0];
    load_data = rdata;
    case (size)
      BYTE:    load_data = {{24{sgn & lane_b[7]}}, lane_b};
      HALF:    load_data = {{16{sgn & lane_h[15]}}, lane_h};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store initiator on a valid/ready data-memory bus.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned accesses trap instead of being aligned).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_rd_en,
  input  logic              mem_wr_en,
  input  logic [7:0]        alu_operation,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [31:0]       reg_data_b,
  output logic [31:0]       memory_data,
  output logic              lsu_stall,
  output logic              bus_err,
  output logic              misaligned,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_rsp_valid,
  input  logic [31:0]       dmem_rsp_rdata
);

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t     state;
  logic [7:0] wait_cnt;
  size_t      size_q;
  signed_t    signed_q;
  logic       store_q;
  logic [1:0] off_q;

  logic       dec_load;
  logic       dec_store;
  size_t      dec_size;
  logic       accept;
  logic       trap_hit;
  logic [1:0] off_in;

  size_t      sel_size;
  signed_t    sel_signed;
  logic       sel_store;
  logic [1:0] sel_off;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_load;

  always_comb begin
    dec_load  = op_is_load(alu_operation);
    dec_store = op_is_store(alu_operation);
    dec_size  = op_size(alu_operation);
    accept    = (state == IDLE) &&
                ((mem_rd_en && !mem_wr_en && dec_load) ||
                 (mem_wr_en && !mem_rd_en && dec_store));
`ifdef LSU_MISALIGN_TRAP_EN
    off_in    = alu_result[1:0];
    trap_hit  = accept && is_misaligned(dec_size, alu_result[1:0]);
`else
    off_in    = align_offset(dec_size, alu_result[1:0]);
    trap_hit  = 1'b0;
`endif
  end

  assign misaligned = trap_hit;
  assign lsu_stall  = accept || (state == REQ) || (state == WAIT_RSP);

  // One lane block serves both paths: store lanes are needed only in the
  // accept cycle (live inputs), load lanes only in WAIT_RSP (captured op).
  always_comb begin
    if (state == IDLE) begin
      sel_size   = dec_size;
      sel_signed = op_signed(alu_operation);
      sel_store  = dec_store;
      sel_off    = off_in;
    end else begin
      sel_size   = size_q;
      sel_signed = signed_q;
      sel_store  = store_q;
      sel_off    = off_q;
    end
  end

  lsu_lane_align u_lane (
    .size       (sel_size),
    .sgn        (sel_signed),
    .store      (sel_store),
    .off        (sel_off),
    .store_data (reg_data_b),
    .rdata      (dmem_rsp_rdata),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .load_data  (lane_load)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      size_q         <= BYTE;
      signed_q       <= 1'b0;
      store_q        <= 1'b0;
      off_q          <= '0;
      memory_data    <= '0;
      bus_err        <= 1'b0;
      dmem_req_valid <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_be        <= '0;
      dmem_wdata     <= '0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            size_q   <= dec_size;
            signed_q <= op_signed(alu_operation);
            store_q  <= dec_store;
            off_q    <= off_in;
            wait_cnt <= '0;
            if (trap_hit) begin
              if (!dec_store) memory_data <= '0;
              state <= DONE;
            end else begin
              dmem_req_valid <= 1'b1;
              dmem_we        <= dec_store;
              dmem_addr      <= {alu_result[ADDR_W-1:2], 2'b00};
              dmem_be        <= lane_be;
              dmem_wdata     <= lane_wdata;
              state          <= REQ;
            end
          end
        end
        REQ: begin
          if (dmem_req_ready) begin
            dmem_req_valid <= 1'b0;
            state          <= store_q ? DONE : WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (dmem_rsp_valid) begin
            memory_data <= lane_load;
            state       <= DONE;
          end else if (wait_cnt == WAIT_LAST) begin
            bus_err     <= 1'b1;
            memory_data <= '0;
            state       <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
